// File: rtl/nlp_link_pkg.sv
// Shared types and default constants for the UART <-> NLProc link controller.
package nlp_link_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_FEED = 2'd1,
        F_CAPT = 2'd2
    } feed_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ACK  = 2'd1,
        T_DONE = 2'd2
    } tx_state_t;

    localparam logic [7:0] NLP_NOMATCH = 8'h00;

    localparam int DEF_NLP_TIMEOUT    = 255;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TX_ACK_TIMEOUT = 16;

endpackage

// File: rtl/nlp_res_fifo.sv
// Small synchronous result FIFO. A push into a full FIFO is accepted when a
// pop happens on the same edge, so the count stays put and order is kept.
module nlp_res_fifo
    import nlp_link_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nlp_link_ctrl.sv
// Scheduler between UART RX, the NLProc keyword core and UART TX.
// Each received byte opens one bounded NLProc window; the first non-zero
// result is queued and later handed to the transmitter with a start/busy
// handshake.
//
// Feed FSM
//   state  | meaning
//   F_IDLE | NLProc cleared; waits for a pending byte
//   F_FEED | NLProc enabled; waits for a match or the window timeout
//   F_CAPT | NLProc cleared; holds the result until the FIFO can take it
// TX FSM
//   state  | meaning
//   T_IDLE | waits for a queued result and an idle transmitter
//   T_ACK  | start issued; waits for busy to rise (bounded)
//   T_DONE | waits for the transmitter to finish
module nlp_link_ctrl
    import nlp_link_pkg::*;
#(
    parameter int NLP_TIMEOUT    = DEF_NLP_TIMEOUT,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TX_ACK_TIMEOUT = DEF_TX_ACK_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [7:0] RX_DATA,
    input  logic       RX_BUSY,
    input  logic [7:0] NLP_SOUT,
    input  logic       TX_BUSY,
    output logic       NLP_CEN,
    output logic [7:0] NLP_DATA,
    output logic       TX_START,
    output logic [7:0] TX_DATA,
    output logic [7:0] LEDG,
    output logic [7:0] LEDR,
    output logic       OVERRUN
);

    localparam int             TW        = $clog2(TX_ACK_TIMEOUT + 1);
    localparam logic [7:0]     FEED_LAST = 8'(NLP_TIMEOUT - 1);
    localparam logic [TW-1:0]  TX_LAST   = TW'(TX_ACK_TIMEOUT - 1);

    logic        r_rx_s1, r_rx_s2, r_rx_d;
    logic        w_rx_fall;
    logic        r_pend_vld;
    logic [7:0]  r_pend_data;
    logic [7:0]  r_ledg;
    logic        r_overrun;

    feed_state_t r_feed, w_feed_nxt;
    logic [7:0]  r_feed_cnt;
    logic [7:0]  r_result;
    logic [7:0]  r_nlp_data;
    logic [7:0]  r_ledr;
    logic        r_cen_q;
    logic        w_launch;
    logic        w_capture;
    logic        w_push;

    tx_state_t   r_tx, w_tx_nxt;
    logic [TW-1:0] r_tx_cnt;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        w_tx_go;

    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;

    assign w_rx_fall = r_rx_d & ~r_rx_s2;

    assign NLP_CEN  = (r_feed == F_FEED);
    assign NLP_DATA = r_nlp_data;
    assign TX_START = r_tx_start;
    assign TX_DATA  = r_tx_data;
    assign LEDG     = r_ledg;
    assign LEDR     = r_ledr;
    assign OVERRUN  = r_overrun;

    // RX_BUSY synchronizer, falling-edge detect and the one-entry pending slot.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_s1     <= 1'b0;
            r_rx_s2     <= 1'b0;
            r_rx_d      <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_ledg      <= 8'h00;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_s1 <= RX_BUSY;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            if (w_rx_fall && r_pend_vld) begin
                r_overrun <= 1'b1;
            end
            // A byte arriving while the slot is occupied is dropped, even if
            // the slot is being drained on the same edge.
            if (w_rx_fall && !r_pend_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= RX_DATA;
                r_ledg      <= RX_DATA;
            end else if (w_launch) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Feed FSM next state. r_cen_q keeps NLP_CEN low for two cycles after a
    // timeout exit as well as after a capture.
    always_comb begin
        w_feed_nxt = r_feed;
        w_launch   = 1'b0;
        w_capture  = 1'b0;
        w_push     = 1'b0;
        case (r_feed)
            F_IDLE: begin
                if (r_pend_vld && !r_cen_q) begin
                    w_launch   = 1'b1;
                    w_feed_nxt = F_FEED;
                end
            end
            F_FEED: begin
                if (NLP_SOUT != NLP_NOMATCH) begin
                    w_capture  = 1'b1;
                    w_feed_nxt = F_CAPT;
                end else if (r_feed_cnt == FEED_LAST) begin
                    w_feed_nxt = F_IDLE;
                end
            end
            F_CAPT: begin
                if (!w_full || w_tx_go) begin
                    w_push     = 1'b1;
                    w_feed_nxt = F_IDLE;
                end
            end
            default: w_feed_nxt = F_IDLE;
        endcase
    end

    // Feed FSM state, window counter and captured-result registers.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_feed     <= F_IDLE;
            r_feed_cnt <= 8'h00;
            r_result   <= 8'h00;
            r_nlp_data <= 8'h00;
            r_ledr     <= 8'h00;
            r_cen_q    <= 1'b0;
        end else begin
            r_feed  <= w_feed_nxt;
            r_cen_q <= NLP_CEN;
            if (w_launch) begin
                r_nlp_data <= r_pend_data;
                r_feed_cnt <= 8'h00;
            end else if (r_feed == F_FEED && !w_capture) begin
                r_feed_cnt <= r_feed_cnt + 8'd1;
            end
            if (w_capture) begin
                r_result <= NLP_SOUT;
                r_ledr   <= NLP_SOUT;
            end
        end
    end

    // TX FSM next state; a start is only issued from T_IDLE with TX idle.
    always_comb begin
        w_tx_nxt = r_tx;
        w_tx_go  = 1'b0;
        case (r_tx)
            T_IDLE: begin
                if (!w_empty && !TX_BUSY) begin
                    w_tx_go  = 1'b1;
                    w_tx_nxt = T_ACK;
                end
            end
            T_ACK: begin
                if (TX_BUSY) begin
                    w_tx_nxt = T_DONE;
                end else if (r_tx_cnt == TX_LAST) begin
                    w_tx_nxt = T_IDLE;
                end
            end
            T_DONE: begin
                if (!TX_BUSY) w_tx_nxt = T_IDLE;
            end
            default: w_tx_nxt = T_IDLE;
        endcase
    end

    // TX FSM state, ack timer, start pulse and held transmit byte.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_tx       <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx       <= w_tx_nxt;
            r_tx_start <= w_tx_go;
            if (w_tx_go) begin
                r_tx_data <= w_head;
                r_tx_cnt  <= '0;
            end else if (r_tx == T_ACK) begin
                r_tx_cnt <= r_tx_cnt + TW'(1);
            end
        end
    end

    nlp_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk       (CLOCK_50),
        .i_rst_n     (RST_N),
        .i_push      (w_push),
        .i_push_data (r_result),
        .i_pop       (w_tx_go),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_nlp_link_ctrl.sv
// Directed bench for nlp_link_ctrl with a simple NLProc stub and an optional
// transmitter model that answers TX_START with a short busy pulse.
module tb_nlp_link_ctrl;

    logic       CLOCK_50;
    logic       RST_N;
    logic [7:0] RX_DATA;
    logic       RX_BUSY;
    logic [7:0] NLP_SOUT;
    logic       TX_BUSY;
    logic       NLP_CEN;
    logic [7:0] NLP_DATA;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic [7:0] LEDG;
    logic [7:0] LEDR;
    logic       OVERRUN;

    logic       stub_en;
    logic [7:0] sout_man;
    logic       tx_auto;
    logic       prev_start;
    logic [7:0] q[$];
    logic [7:0] d0, d1;
    logic [7:0] exp3 [6];

    int n_err, n_checks;
    int cyc, busy_cnt, viol;
    int first_start, first_cen, n_start, cen_cnt, s0, s1;

    // NLProc stand-in: answers data+0x10 while enabled, or a manual value.
    assign NLP_SOUT = stub_en ? (NLP_CEN ? (NLP_DATA + 8'h10) : 8'h00) : sout_man;

    nlp_link_ctrl dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .RX_DATA  (RX_DATA),
        .RX_BUSY  (RX_BUSY),
        .NLP_SOUT (NLP_SOUT),
        .TX_BUSY  (TX_BUSY),
        .NLP_CEN  (NLP_CEN),
        .NLP_DATA (NLP_DATA),
        .TX_START (TX_START),
        .TX_DATA  (TX_DATA),
        .LEDG     (LEDG),
        .LEDR     (LEDR),
        .OVERRUN  (OVERRUN)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, watch start-pulse rules, run TX model.
    task automatic step();
        logic busy_before;
        busy_before = TX_BUSY;
        @(negedge CLOCK_50);
        cyc++;
        if (TX_START && (prev_start || busy_before)) viol++;
        prev_start = TX_START;
        if (tx_auto) begin
            if (TX_START) begin
                q.push_back(TX_DATA);
                busy_cnt = 3;
                TX_BUSY  = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) TX_BUSY = 1'b0;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX_DATA = b;
        RX_BUSY = 1'b1;
        repeat (3) step();
        RX_BUSY = 1'b0;
    endtask

    initial begin
        n_err = 0; n_checks = 0; cyc = 0; busy_cnt = 0; viol = 0;
        prev_start = 1'b0; tx_auto = 1'b0;
        stub_en = 1'b0; sout_man = 8'h00;
        RST_N = 1'b0; RX_DATA = 8'h00; RX_BUSY = 1'b0; TX_BUSY = 1'b0;
        exp3 = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

        // Reset state
        repeat (3) step();
        chk("rst_outputs", {NLP_CEN, NLP_DATA, TX_START, TX_DATA, LEDG, LEDR, OVERRUN}, 32'h0);
        RST_N = 1'b1;
        repeat (3) step();
        chk("idle_cen", NLP_CEN, 1'b0);

        // Byte 0x41, match 0x07 on the 5th FEED cycle
        send_rx(8'h41);
        repeat (3) step();
        chk("t1_ledg_load", LEDG, 8'h41);
        chk("t1_cen_before", NLP_CEN, 1'b0);
        step();
        chk("t1_cen_high", NLP_CEN, 1'b1);
        chk("t1_nlp_data", NLP_DATA, 8'h41);
        repeat (3) step();
        sout_man = 8'h07;
        step();
        chk("t1_ledr", LEDR, 8'h07);
        chk("t1_cen_capt", NLP_CEN, 1'b0);
        sout_man = 8'h00;
        step();
        chk("t1_no_start_at_push", TX_START, 1'b0);
        step();
        chk("t1_tx_start", TX_START, 1'b1);
        chk("t1_tx_data", TX_DATA, 8'h07);
        TX_BUSY = 1'b1;
        step();
        chk("t1_start_one_cycle", TX_START, 1'b0);
        repeat (2) step();
        TX_BUSY = 1'b0;
        repeat (3) step();
        chk("t1_ledg", LEDG, 8'h41);
        chk("t1_ledr_hold", LEDR, 8'h07);
        chk("t1_tx_data_hold", TX_DATA, 8'h07);

        // Byte 0x42 with no match: window of exactly 255 cycles
        send_rx(8'h42);
        cen_cnt = 0; n_start = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (NLP_CEN) cen_cnt++;
            if (TX_START) n_start++;
        end
        chk("t2_cen_cycles", cen_cnt, 255);
        chk("t2_no_start", n_start, 0);
        chk("t2_ledr_kept", LEDR, 8'h07);

        // Back-pressure: 4 queued, 5th stalls, 6th pending, 7th overruns
        stub_en = 1'b1;
        TX_BUSY = 1'b1;
        for (int b = 0; b < 6; b++) begin
            send_rx(8'h50 + 8'(b));
            repeat (8) step();
        end
        chk("t3_overrun_clear", OVERRUN, 1'b0);
        chk("t3_ledr_5th", LEDR, 8'h64);
        chk("t3_ledg_6th", LEDG, 8'h55);
        chk("t3_stalled_cen", NLP_CEN, 1'b0);
        send_rx(8'h56);
        repeat (6) step();
        chk("t3_overrun_set", OVERRUN, 1'b1);
        q.delete();
        busy_cnt = 0;
        TX_BUSY = 1'b0;
        tx_auto = 1'b1;
        first_start = -1; first_cen = -1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (TX_START && first_start < 0) first_start = i;
            if (NLP_CEN && first_cen < 0) first_cen = i;
        end
        chk("t3_push_with_pop_full", first_cen - first_start, 1);
        chk("t3_tx_count", q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_order%0d", i),
                (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));
        end
        tx_auto = 1'b0;
        TX_BUSY = 1'b0;

        // Transmitter never acknowledges: 16-cycle ack timeout
        TX_BUSY = 1'b1;
        send_rx(8'h30);
        repeat (8) step();
        send_rx(8'h31);
        repeat (8) step();
        TX_BUSY = 1'b0;
        n_start = 0; s0 = 0; s1 = 0; d0 = 8'h00; d1 = 8'h00;
        for (int i = 0; i < 60; i++) begin
            step();
            if (TX_START) begin
                if (n_start == 0) begin s0 = i; d0 = TX_DATA; end
                if (n_start == 1) begin s1 = i; d1 = TX_DATA; end
                n_start++;
            end
        end
        chk("t4_start_count", n_start, 2);
        chk("t4_first_data", d0, 8'h40);
        chk("t4_second_data", d1, 8'h41);
        chk("t4_timeout_gap", s1 - s0, 17);

        // Reset mid-window with two queued results
        TX_BUSY = 1'b1;
        send_rx(8'h20);
        repeat (8) step();
        send_rx(8'h21);
        repeat (8) step();
        stub_en = 1'b0;
        sout_man = 8'h00;
        send_rx(8'h22);
        repeat (4) step();
        chk("t6_window_open", NLP_CEN, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_async_cen", NLP_CEN, 1'b0);
        chk("t6_async_all", {NLP_CEN, NLP_DATA, TX_START, TX_DATA, LEDG, LEDR, OVERRUN}, 32'h0);
        step();
        RST_N = 1'b1;
        TX_BUSY = 1'b0;
        busy_cnt = 0;
        tx_auto = 1'b1;
        q.delete();
        n_start = 0; cen_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (TX_START) n_start++;
            if (NLP_CEN) cen_cnt++;
        end
        chk("t6_no_start", n_start, 0);
        chk("t6_no_window", cen_cnt, 0);
        chk("t6_overrun_cleared", OVERRUN, 1'b0);
        stub_en = 1'b1;
        send_rx(8'h23);
        repeat (30) step();
        chk("t6_new_tx_count", q.size(), 1);
        chk("t6_new_tx_data", (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF, 32'h33);
        tx_auto = 1'b0;

        chk("start_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nlp_link_ctrl.md
# nlp_link_ctrl

Sequencing controller between the UART receiver, the NLProc keyword core and the UART transmitter in the speech-processing top level. It turns each received byte into one bounded NLProc evaluation window, captures the first non-zero result into a small result FIFO, and drains that FIFO to the transmitter with a full start/busy handshake. It replaces ad-hoc level-triggered glue with one clocked, reset-clean scheduler.

## Interface
- NLP_TIMEOUT, 255: max cycles NLP_CEN stays high waiting for a non-zero NLP_SOUT (1..255).
- FIFO_DEPTH, 4: result FIFO entries (power of two, 2..16).
- TX_ACK_TIMEOUT, 16: max cycles waiting for TX_BUSY to rise after TX_START.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- RX_DATA  in  8  received byte; stable while RX_BUSY is low.
- RX_BUSY  in  1  receiver busy; falling edge marks a new byte.
- NLP_SOUT  in  8  NLProc result; 0x00 means no match yet.
- TX_BUSY  in  1  transmitter busy.
- NLP_CEN  out  1  NLProc enable; low clears NLProc.
- NLP_DATA  out  8  byte presented to NLProc.
- TX_START  out  1  one-cycle transmit request.
- TX_DATA  out  8  byte to transmit.
- LEDG  out  8  last received byte.
- LEDR  out  8  last captured result.
- OVERRUN  out  1  sticky: an RX byte was dropped.

## Operation
- Reset: all outputs 0, both FSMs idle, FIFO empty, pending register empty, OVERRUN 0.
- RX_BUSY passes through a 2-flop synchronizer; a registered falling-edge detect loads RX_DATA into a 1-entry pending register and LEDG.
- Edge while pending is full: byte dropped, OVERRUN set (cleared only by reset).
- Feed FSM states: F_IDLE, F_FEED, F_CAPT.
  - F_IDLE: NLP_CEN=0; pending valid -> F_FEED, NLP_DATA<=pending, pending cleared, counter<=0.
  - F_FEED: NLP_CEN=1; NLP_SOUT!=0 -> result reg<=NLP_SOUT, LEDR<=NLP_SOUT, -> F_CAPT; counter reaching NLP_TIMEOUT-1 with NLP_SOUT==0 -> F_IDLE, no push.
  - F_CAPT: NLP_CEN=0; FIFO not full -> push result, -> F_IDLE; FIFO full -> stall in F_CAPT (pending may still fill; further bytes overrun).
- TX FSM states: T_IDLE, T_ACK, T_DONE.
  - T_IDLE: FIFO non-empty and TX_BUSY==0 -> TX_START=1 one cycle, TX_DATA<=head, pop, -> T_ACK.
  - T_ACK: TX_BUSY==1 -> T_DONE; TX_ACK_TIMEOUT cycles without it -> T_IDLE (byte counted as sent).
  - T_DONE: TX_BUSY==0 -> T_IDLE.
  - TX_DATA holds its value until the next TX_START.
- Push and pop in the same cycle with FIFO full: both accepted, count unchanged.
- Push and pop in the same cycle with FIFO empty: not possible (pop needs non-empty at cycle start).
- FIFO pointers wrap modulo FIFO_DEPTH; the count width is clog2(FIFO_DEPTH)+1.

## Timing
- RX_BUSY fall to pending load: 3 cycles. Pending load to NLP_CEN high: 1 cycle.
- NLP_SOUT non-zero at edge k: LEDR updates at k, and the FIFO push happens at k+1 (if not full).
- NLP_CEN low for at least 2 consecutive cycles between windows (F_CAPT/timeout exit + F_IDLE).
- FIFO push to TX_START: 1 cycle minimum (FIFO non-empty registered, TX_BUSY low, T_IDLE).
- TX_START never asserts on two consecutive cycles; never while TX_BUSY=1.
- RST_N low mid-window or mid-transmit: NLP_CEN and TX_START drop immediately (async). The FIFO, pending register and sticky flag clear.

## Structure
- Package nlp_link_pkg: feed_state_t and tx_state_t enums, NLP_NOMATCH=8'h00, default parameter constants.
- Sub-module nlp_res_fifo: synchronous FIFO (push, pop, full, empty, head), parameterised on FIFO_DEPTH and width 8, async active-low reset.
- Synchronizer and edge detect stay inline.

## Test plan
- RX byte 0x41, NLP_SOUT=0x07 on the 5th FEED cycle -> one push; TX_START pulse with TX_DATA=0x07; LEDG=0x41, LEDR=0x07.
- RX byte 0x42, NLP_SOUT held 0 -> NLP_CEN high for exactly 255 cycles, then low; no TX_START.
- TX_BUSY held high; send 6 matching bytes -> 4 queued, F_CAPT stalls on the 5th, and the 6th fills pending. A 7th sets OVERRUN. Release TX_BUSY -> 0x.. results transmitted in order.
- TX_BUSY never rises after TX_START -> T_IDLE after 16 cycles; the next queued byte is sent.
- FIFO full with pop and push on the same edge -> count stays 4, order preserved.
- RST_N pulsed low while NLP_CEN=1 and the FIFO holds 2 entries -> all outputs 0 immediately; no TX_START after release until a new byte arrives.
